// File: rtl/platform_link_tx_if.sv
// Link bundle between the vector generator FIFO, the chip-link transmitter and the chip side.
//   master : the transmitter (platform_link_tx). It samples en/work/data/empty and drives
//            require/tx/shakehand/busy/blocks_sent (plus tx_parity when enabled).
//   slave  : the environment (FIFO, pacing divider, chip model or bench).
// Signals:
//   en          pacing tick, one clk wide
//   work        level, permits starting new blocks
//   data        FIFO head word, show-ahead, valid while !empty
//   empty       FIFO empty
//   require     FIFO pop strobe
//   tx          current beat
//   shakehand   toggles once per beat
//   busy        transmitter in SHIFT or GAP
//   blocks_sent completed block count
//   tx_parity   XOR of the bits of tx; only with PLATFORM_LINK_TX_PARITY_EN defined
interface platform_link_tx_if #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned LANE_W  = 8,
    parameter int unsigned CNT_W   = 32
);
    logic               en;
    logic               work;
    logic [BLOCK_W-1:0] data;
    logic               empty;
    logic               require;
    logic [LANE_W-1:0]  tx;
    logic               shakehand;
    logic               busy;
    logic [CNT_W-1:0]   blocks_sent;
`ifdef PLATFORM_LINK_TX_PARITY_EN
    logic               tx_parity;
`endif

    modport master (
        input  en,
        input  work,
        input  data,
        input  empty,
        output require,
        output tx,
        output shakehand,
        output busy,
        output blocks_sent
`ifdef PLATFORM_LINK_TX_PARITY_EN
        , output tx_parity
`endif
    );

    modport slave (
        output en,
        output work,
        output data,
        output empty,
        input  require,
        input  tx,
        input  shakehand,
        input  busy,
        input  blocks_sent
`ifdef PLATFORM_LINK_TX_PARITY_EN
        , input tx_parity
`endif
    );
endinterface

// File: rtl/platform_link_tx.sv
// Chip-link transmitter. Pops BLOCK_W-bit words from a show-ahead FIFO and sends them MSB-first
// as LANE_W-bit beats, one beat per pacing tick, each beat marked by a shakehand toggle.
// After every block the link idles for GAP_TICKS pacing ticks.
// Ports:
//   clk      platform clock
//   rst_n    asynchronous active-low reset
//   io_link  link bundle (master side): en, work, data, empty in;
//            require, tx, shakehand, busy, blocks_sent out
// Optional feature: define PLATFORM_LINK_TX_PARITY_EN to add io_link.tx_parity, the XOR of
// the beat bits, registered together with tx.
module platform_link_tx #(
    parameter int unsigned BLOCK_W   = 128,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned GAP_TICKS = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    platform_link_tx_if.master io_link
);
    localparam int unsigned BEATS = BLOCK_W / LANE_W;
    localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned GapW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e             r_state,    w_state_d;
    logic [BLOCK_W-1:0] r_shift,    w_shift_d;
    logic [BeatW-1:0]   r_beat_cnt, w_beat_cnt_d;
    logic [GapW-1:0]    r_gap_cnt,  w_gap_cnt_d;
    logic [LANE_W-1:0]  r_tx,       w_tx_d;
    logic               r_shake,    w_shake_d;
    logic [CNT_W-1:0]   r_blocks,   w_blocks_d;
    logic               w_start;
    logic [LANE_W-1:0]  w_beat;

    assign w_beat = r_shift[BLOCK_W-1 -: LANE_W];

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_beat_cnt_d = r_beat_cnt;
        w_gap_cnt_d  = r_gap_cnt;
        w_tx_d       = r_tx;
        w_shake_d    = r_shake;
        w_blocks_d   = r_blocks;
        w_start      = 1'b0;
        if (io_link.en) begin
            unique case (r_state)
                StIdle: begin
                    // empty is only looked at here, so a pop can never hit an empty FIFO
                    if (io_link.work && !io_link.empty) begin
                        w_start      = 1'b1;
                        w_shift_d    = io_link.data;
                        w_beat_cnt_d = '0;
                        w_state_d    = StShift;
                    end
                end
                StShift: begin
                    w_tx_d       = w_beat;
                    w_shake_d    = ~r_shake;
                    w_shift_d    = r_shift << LANE_W;
                    w_beat_cnt_d = r_beat_cnt + BeatW'(1);
                    if (r_beat_cnt == BeatW'(BEATS - 1)) begin
                        w_blocks_d   = r_blocks + CNT_W'(1);
                        w_beat_cnt_d = '0;
                        w_gap_cnt_d  = GapW'(GAP_TICKS);
                        w_state_d    = (GAP_TICKS == 0) ? StIdle : StGap;
                    end
                end
                StGap: begin
                    w_gap_cnt_d = r_gap_cnt - GapW'(1);
                    if (r_gap_cnt <= GapW'(1)) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_tx       <= '0;
            r_shake    <= 1'b0;
            r_blocks   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_beat_cnt <= w_beat_cnt_d;
            r_gap_cnt  <= w_gap_cnt_d;
            r_tx       <= w_tx_d;
            r_shake    <= w_shake_d;
            r_blocks   <= w_blocks_d;
        end
    end

    // The pop strobe is combinational so the FIFO advances on the same tick the word is
    // captured; masking with rst_n keeps it low while reset is held.
    assign io_link.require     = w_start & rst_n;
    assign io_link.tx          = r_tx;
    assign io_link.shakehand   = r_shake;
    assign io_link.busy        = (r_state != StIdle);
    assign io_link.blocks_sent = r_blocks;

`ifdef PLATFORM_LINK_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (io_link.en && (r_state == StShift)) begin
            r_parity <= ^w_beat;
        end
    end

    assign io_link.tx_parity = r_parity;
`endif
endmodule

// File: tb/tb_platform_link_tx.sv
module tb_platform_link_tx;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BEATS   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    platform_link_tx_if #(.BLOCK_W(BLOCK_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) lnk ();
    platform_link_tx_if #(.BLOCK_W(BLOCK_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) lnk0 ();

    platform_link_tx #(.BLOCK_W(BLOCK_W), .LANE_W(LANE_W), .GAP_TICKS(2), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_link (lnk.master)
    );

    platform_link_tx #(.BLOCK_W(BLOCK_W), .LANE_W(LANE_W), .GAP_TICKS(0), .CNT_W(CNT_W)) u_dut_g0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_link (lnk0.master)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [BLOCK_W-1:0] fifo_a[$];
    logic [BLOCK_W-1:0] fifo_b[$];
    logic [LANE_W-1:0]  exp_a[$];
    logic [LANE_W-1:0]  obs_a[$];
    logic [LANE_W-1:0]  exp_b[$];
    logic [LANE_W-1:0]  obs_b[$];
    logic               obs_par[$];
    int                 pop_ticks_a[$];
    int                 pop_ticks_b[$];
    int                 beat_ticks_a[$];
    int                 beat_ticks_b[$];
    int                 tick_no;
    int                 req_empty_viol;
    logic               prev_sh_a;
    logic               prev_sh_b;

    // One clk: drive inputs at negedge, sample require before the edge, log beats after it.
    task automatic step(input bit en_v);
        bit ra;
        bit rb;
        @(negedge clk);
        if (en_v) tick_no++;
        lnk.en     = en_v;
        lnk0.en    = en_v;
        lnk.empty  = (fifo_a.size() == 0);
        lnk.data   = (fifo_a.size() != 0) ? fifo_a[0] : '0;
        lnk0.empty = (fifo_b.size() == 0);
        lnk0.data  = (fifo_b.size() != 0) ? fifo_b[0] : '0;
        #1;
        ra = lnk.require;
        rb = lnk0.require;
        if (ra && lnk.empty) req_empty_viol++;
        if (rb && lnk0.empty) req_empty_viol++;
        @(posedge clk);
        #1;
        if (ra) begin
            fifo_a.delete(0);
            pop_ticks_a.push_back(tick_no);
        end
        if (rb) begin
            fifo_b.delete(0);
            pop_ticks_b.push_back(tick_no);
        end
        if (rst_n && (lnk.shakehand !== prev_sh_a)) begin
            prev_sh_a = lnk.shakehand;
            obs_a.push_back(lnk.tx);
            beat_ticks_a.push_back(tick_no);
`ifdef PLATFORM_LINK_TX_PARITY_EN
            obs_par.push_back(lnk.tx_parity);
`endif
        end
        if (rst_n && (lnk0.shakehand !== prev_sh_b)) begin
            prev_sh_b = lnk0.shakehand;
            obs_b.push_back(lnk0.tx);
            beat_ticks_b.push_back(tick_no);
        end
    endtask

    // en every 5 clk
    task automatic tick();
        step(1'b1);
        repeat (4) step(1'b0);
    endtask

    task automatic clear_logs();
        fifo_a.delete(); fifo_b.delete();
        exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete(); obs_par.delete();
        pop_ticks_a.delete(); pop_ticks_b.delete();
        beat_ticks_a.delete(); beat_ticks_b.delete();
        tick_no = 0;
        req_empty_viol = 0;
        prev_sh_a = 1'b0;
        prev_sh_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        lnk.en    = 1'b0;
        lnk0.en   = 1'b0;
        lnk.work  = 1'b1;
        lnk0.work = 1'b1;
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stimulus side of the scoreboard: the word enters the FIFO model and, when expected to
    // go out, its beats go to the expected queue MSB-first.
    task automatic push_a(input logic [BLOCK_W-1:0] w, input bit expect_out);
        fifo_a.push_back(w);
        if (expect_out)
            for (int i = 0; i < int'(BEATS); i++) exp_a.push_back(w[BLOCK_W-1-LANE_W*i -: LANE_W]);
    endtask

    task automatic push_b(input logic [BLOCK_W-1:0] w);
        fifo_b.push_back(w);
        for (int i = 0; i < int'(BEATS); i++) exp_b.push_back(w[BLOCK_W-1-LANE_W*i -: LANE_W]);
    endtask

    function automatic logic [BLOCK_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        lnk.en     = 1'b1;
        lnk.work   = 1'b1;
        lnk.empty  = 1'b0;
        lnk.data   = rand_word();
        #1;
        vectors += 5;
        if (lnk.require !== 1'b0) begin
            miscompares++; $display("FAIL reset require: got %b, expected 0", lnk.require);
        end
        if (lnk.tx !== 8'h00) begin
            miscompares++; $display("FAIL reset tx: got %h, expected 00", lnk.tx);
        end
        if (lnk.shakehand !== 1'b0) begin
            miscompares++; $display("FAIL reset shakehand: got %b, expected 0", lnk.shakehand);
        end
        if (lnk.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset busy: got %b, expected 0", lnk.busy);
        end
        if (lnk.blocks_sent !== 32'd0) begin
            miscompares++; $display("FAIL reset blocks_sent: got %0d, expected 0", lnk.blocks_sent);
        end
`ifdef PLATFORM_LINK_TX_PARITY_EN
        vectors++;
        if (lnk.tx_parity !== 1'b0) begin
            miscompares++; $display("FAIL reset tx_parity: got %b, expected 0", lnk.tx_parity);
        end
`endif
        lnk.en    = 1'b0;
        lnk.empty = 1'b1;
    endtask

    task automatic test_empty();
        do_reset();
        repeat (200) tick();
        vectors += 5;
        if (pop_ticks_a.size() != 0 || req_empty_viol != 0) begin
            miscompares++;
            $display("FAIL empty require: got %0d pops, expected 0", pop_ticks_a.size());
        end
        if (lnk.tx !== 8'h00) begin
            miscompares++; $display("FAIL empty tx: got %h, expected 00", lnk.tx);
        end
        if (lnk.shakehand !== 1'b0) begin
            miscompares++; $display("FAIL empty shakehand: got %b, expected 0", lnk.shakehand);
        end
        if (lnk.busy !== 1'b0) begin
            miscompares++; $display("FAIL empty busy: got %b, expected 0", lnk.busy);
        end
        if (obs_a.size() != 0) begin
            miscompares++; $display("FAIL empty beats: got %0d, expected 0", obs_a.size());
        end
    endtask

    task automatic test_single_block();
        int n;
        logic [LANE_W-1:0] e;
        logic [LANE_W-1:0] o;
        do_reset();
        push_a(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        tick();
        vectors++;
        if (lnk.busy !== 1'b1) begin
            miscompares++; $display("FAIL single busy: got %b, expected 1", lnk.busy);
        end
        n = 0;
        while (!(lnk.blocks_sent == 32'd1 && !lnk.busy) && n < 40) begin
            tick(); n++;
        end
        vectors++;
        if (n >= 40) begin
            miscompares++; $display("FAIL single timeout: got %0d ticks, expected <40", n);
        end
        repeat (5) tick();
        vectors += 4;
        if (pop_ticks_a.size() != 1) begin
            miscompares++; $display("FAIL single pops: got %0d, expected 1", pop_ticks_a.size());
        end
        if (obs_a.size() != int'(BEATS)) begin
            miscompares++; $display("FAIL single toggles: got %0d, expected 16", obs_a.size());
        end
        if (lnk.blocks_sent !== 32'd1) begin
            miscompares++; $display("FAIL single blocks_sent: got %0d, expected 1", lnk.blocks_sent);
        end
        if (pop_ticks_a.size() == 1 && beat_ticks_a.size() == int'(BEATS)) begin
            if (beat_ticks_a[0] != pop_ticks_a[0] + 1 || beat_ticks_a[15] != pop_ticks_a[0] + 16) begin
                miscompares++;
                $display("FAIL single latency: got beat0 %0d last %0d, expected %0d and %0d",
                         beat_ticks_a[0], beat_ticks_a[15], pop_ticks_a[0] + 1, pop_ticks_a[0] + 16);
            end
        end else begin
            miscompares++; $display("FAIL single latency: got no timing data, expected 1 pop 16 beats");
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() != 0) ? obs_a.pop_front() : 8'hxx;
            vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL single beat: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_gap();
        int n;
        logic [LANE_W-1:0] e;
        logic [LANE_W-1:0] o;
        do_reset();
        push_a(rand_word(), 1'b1);
        push_a(rand_word(), 1'b1);
        n = 0;
        while (!(lnk.blocks_sent == 32'd2 && !lnk.busy) && n < 60) begin
            tick(); n++;
        end
        vectors += 3;
        if (n >= 60) begin
            miscompares++; $display("FAIL gap timeout: got %0d ticks, expected <60", n);
        end
        if (pop_ticks_a.size() != 2) begin
            miscompares++; $display("FAIL gap pops: got %0d, expected 2", pop_ticks_a.size());
        end else if (pop_ticks_a[1] - pop_ticks_a[0] != 19) begin
            miscompares++;
            $display("FAIL gap spacing: got %0d ticks, expected 19", pop_ticks_a[1] - pop_ticks_a[0]);
        end
        if (obs_a.size() != 2 * int'(BEATS)) begin
            miscompares++; $display("FAIL gap beats: got %0d, expected 32", obs_a.size());
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() != 0) ? obs_a.pop_front() : 8'hxx;
            vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL gap beat: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [LANE_W-1:0] e;
        logic [LANE_W-1:0] o;
        do_reset();
        push_b(rand_word());
        push_b(rand_word());
        n = 0;
        while (!(lnk0.blocks_sent == 32'd2 && !lnk0.busy) && n < 60) begin
            tick(); n++;
        end
        repeat (3) tick();
        vectors += 5;
        if (n >= 60) begin
            miscompares++; $display("FAIL b2b timeout: got %0d ticks, expected <60", n);
        end
        if (pop_ticks_b.size() != 2 || req_empty_viol != 0) begin
            miscompares++; $display("FAIL b2b pops: got %0d, expected 2", pop_ticks_b.size());
        end else if (pop_ticks_b[1] - pop_ticks_b[0] != 17) begin
            miscompares++;
            $display("FAIL b2b spacing: got %0d ticks, expected 17", pop_ticks_b[1] - pop_ticks_b[0]);
        end
        if (beat_ticks_b.size() != 2 * int'(BEATS)) begin
            miscompares++; $display("FAIL b2b beats: got %0d, expected 32", beat_ticks_b.size());
        end else if (beat_ticks_b[16] != beat_ticks_b[15] + 2) begin
            // pop occupies the tick between the two blocks
            miscompares++;
            $display("FAIL b2b seam: got %0d, expected %0d", beat_ticks_b[16], beat_ticks_b[15] + 2);
        end
        if (lnk0.blocks_sent !== 32'd2) begin
            miscompares++; $display("FAIL b2b blocks_sent: got %0d, expected 2", lnk0.blocks_sent);
        end
        if (pop_ticks_a.size() != 0) begin
            miscompares++; $display("FAIL b2b idle dut: got %0d pops, expected 0", pop_ticks_a.size());
        end
        while (exp_b.size() != 0) begin
            e = exp_b.pop_front();
            o = (obs_b.size() != 0) ? obs_b.pop_front() : 8'hxx;
            vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL b2b beat: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_work_drop();
        int n;
        logic [LANE_W-1:0] e;
        logic [LANE_W-1:0] o;
        do_reset();
        push_a(rand_word(), 1'b1);
        push_a(rand_word(), 1'b0);
        push_a(rand_word(), 1'b0);
        n = 0;
        while (obs_a.size() < 6 && n < 20) begin
            tick(); n++;
        end
        lnk.work = 1'b0;
        while (!(lnk.blocks_sent == 32'd1 && !lnk.busy) && n < 60) begin
            tick(); n++;
        end
        repeat (10) tick();
        vectors += 4;
        if (n >= 60) begin
            miscompares++; $display("FAIL drop timeout: got %0d ticks, expected <60", n);
        end
        if (pop_ticks_a.size() != 1 || fifo_a.size() != 2) begin
            miscompares++;
            $display("FAIL drop pops: got %0d (fifo %0d), expected 1 (fifo 2)",
                     pop_ticks_a.size(), fifo_a.size());
        end
        if (lnk.blocks_sent !== 32'd1) begin
            miscompares++; $display("FAIL drop blocks_sent: got %0d, expected 1", lnk.blocks_sent);
        end
        if (obs_a.size() != int'(BEATS)) begin
            miscompares++; $display("FAIL drop beats: got %0d, expected 16", obs_a.size());
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() != 0) ? obs_a.pop_front() : 8'hxx;
            vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL drop beat: got %h, expected %h", o, e);
            end
        end
        lnk.work = 1'b1;
    endtask

    task automatic test_reset_mid_block();
        int n;
        logic [LANE_W-1:0] e;
        logic [LANE_W-1:0] o;
        do_reset();
        push_a(rand_word(), 1'b0);
        n = 0;
        while (obs_a.size() < 8 && n < 20) begin
            tick(); n++;
        end
        #2;
        rst_n   = 1'b0;
        lnk.en  = 1'b1;
        lnk.empty = 1'b0;
        #1;
        vectors += 5;
        if (lnk.tx !== 8'h00) begin
            miscompares++; $display("FAIL midrst tx: got %h, expected 00", lnk.tx);
        end
        if (lnk.shakehand !== 1'b0) begin
            miscompares++; $display("FAIL midrst shakehand: got %b, expected 0", lnk.shakehand);
        end
        if (lnk.busy !== 1'b0) begin
            miscompares++; $display("FAIL midrst busy: got %b, expected 0", lnk.busy);
        end
        if (lnk.blocks_sent !== 32'd0) begin
            miscompares++; $display("FAIL midrst blocks_sent: got %0d, expected 0", lnk.blocks_sent);
        end
        if (lnk.require !== 1'b0) begin
            miscompares++; $display("FAIL midrst require: got %b, expected 0", lnk.require);
        end
        lnk.en = 1'b0;
        lnk.empty = 1'b1;
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_a(rand_word(), 1'b1);
        n = 0;
        while (!(lnk.blocks_sent == 32'd1 && !lnk.busy) && n < 40) begin
            tick(); n++;
        end
        vectors += 3;
        if (n >= 40) begin
            miscompares++; $display("FAIL midrst timeout: got %0d ticks, expected <40", n);
        end
        if (pop_ticks_a.size() != 1) begin
            miscompares++; $display("FAIL midrst pops: got %0d, expected 1", pop_ticks_a.size());
        end
        if (obs_a.size() != int'(BEATS)) begin
            miscompares++; $display("FAIL midrst beats: got %0d, expected 16", obs_a.size());
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            o = (obs_a.size() != 0) ? obs_a.pop_front() : 8'hxx;
            vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL midrst beat: got %h, expected %h", o, e);
            end
        end
    endtask

`ifdef PLATFORM_LINK_TX_PARITY_EN
    task automatic test_parity();
        int n;
        logic [LANE_W-1:0] e;
        logic              p;
        do_reset();
        push_a({8'h07, 8'h03, 112'h0}, 1'b1);
        n = 0;
        while (!(lnk.blocks_sent == 32'd1 && !lnk.busy) && n < 40) begin
            tick(); n++;
        end
        vectors += 2;
        if (obs_par.size() != int'(BEATS)) begin
            miscompares++; $display("FAIL parity beats: got %0d, expected 16", obs_par.size());
        end
        if (obs_par.size() >= 2 && (obs_par[0] !== 1'b1 || obs_par[1] !== 1'b0)) begin
            miscompares++;
            $display("FAIL parity first: got %b%b, expected 10", obs_par[0], obs_par[1]);
        end
        while (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            p = (obs_par.size() != 0) ? obs_par.pop_front() : 1'bx;
            vectors++;
            if (p !== ^e) begin
                miscompares++; $display("FAIL parity beat %h: got %b, expected %b", e, p, ^e);
            end
        end
    endtask
`endif

    initial begin
        lnk.en = 1'b0;  lnk.work = 1'b0;  lnk.empty = 1'b1;  lnk.data = '0;
        lnk0.en = 1'b0; lnk0.work = 1'b0; lnk0.empty = 1'b1; lnk0.data = '0;
        clear_logs();
        test_reset();
        test_empty();
        test_single_block();
        test_gap();
        test_back_to_back();
        test_work_drop();
        test_reset_mid_block();
`ifdef PLATFORM_LINK_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
